freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter_pkg.sv | 31 +++
 rtl/freq_meter_sync_edge_detect.sv | 47 ++++
 rtl/freq_meter.sv | 179 +++++++++++++++++
 tb/tb_freq_meter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg
//   Shared types and constants for the frequency meter: FSM state encoding,
//   datapath widths, the no-edge timeout limit and a saturating accumulate.
package freq_meter_pkg;

   localparam int CNT_W = 16;
   localparam int ACC_W = 16;
   localparam int PER_W = 8;

   localparam logic [CNT_W-1:0] TIMEOUT_MAX = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_MEASURE = 3'd2,
      ST_DONE    = 3'd3
   } state_e;

   // Adds one period sample (up to 2^CNT_W) to the accumulator, clamping at
   // all-ones instead of wrapping.
   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                input logic [CNT_W:0]   sample);
      logic [ACC_W+1:0] sum;
      sum = {2'b00, acc} + {1'b0, sample};
      if (sum > {2'b00, {ACC_W{1'b1}}}) begin
         return {ACC_W{1'b1}};
      end
      return sum[ACC_W-1:0];
   endfunction

endpackage

// File: rtl/freq_meter_sync_edge_detect.sv
// sync_edge_detect
//   Brings an asynchronous input into the clk domain with a two-flop
//   synchronizer, keeps the previous synchronized value and emits a registered
//   one-cycle pulse on each rising edge. An input edge shows up on rise three
//   clk cycles later.
//
// Ports
//   clk   in   clock
//   rst   in   asynchronous active-high reset
//   d     in   asynchronous input
//   rise  out  one-cycle rising-edge pulse
module sync_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;
   logic rise_q,  rise_d;

   always_comb begin
      sync1_d = d;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      rise_d  = sync2_q & ~prev_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         rise_q  <= rise_d;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/freq_meter.sv
// freq_meter
//   Measures the period of sig_in in clk cycles, averaged over 2^n periods.
//   A no-edge timeout aborts a measurement when sig_in stops toggling.
//
// Ports
//   clk       in   reference clock
//   rst       in   asynchronous active-high reset
//   sig_in    in   waveform under measurement (asynchronous)
//   start     in   measurement request, honoured in IDLE and DONE
//   n         in   averaging exponent, latched on start
//   k_exp     in   expected period for the match flag, read at completion
//   period    out  averaged period, saturated at 255
//   done      out  one-cycle completion pulse
//   match     out  last result within +/-1 of k_exp
//   timeout   out  last measurement aborted for a missing edge
//   curState  out  current FSM state
//
// state   | meaning
// IDLE    | after reset, waiting for start
// ARM     | waiting for the first rising edge; cnt doubles as timeout timer
// MEASURE | counting clk cycles between edges, accumulating 2^n samples
// DONE    | result valid and held; start re-arms
module freq_meter
   import freq_meter_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             start,
   input  logic [2:0]       n,
   input  logic [PER_W-1:0] k_exp,
   output logic [PER_W-1:0] period,
   output logic             done,
   output logic             match,
   output logic             timeout,
   output logic [2:0]       curState
);

   logic rise;

   sync_edge_detect u_sync_edge_detect (
      .clk  (clk),
      .rst  (rst),
      .d    (sig_in),
      .rise (rise)
   );

   state_e           state_q,   state_d;
   logic [2:0]       n_r_q,     n_r_d;
   logic [ACC_W-1:0] acc_q,     acc_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [PER_W-1:0] per_cnt_q, per_cnt_d;
   logic [PER_W-1:0] period_q,  period_d;
   logic             done_q,    done_d;
   logic             match_q,   match_d;
   logic             timeout_q, timeout_d;

   logic [CNT_W:0]        sample;
   logic [ACC_W-1:0]      acc_new;
   logic [ACC_W-1:0]      acc_avg;
   logic                  avg_ovf;
   logic [PER_W-1:0]      period_new;
   logic signed [PER_W:0] diff;
   logic                  in_tol;
   logic [PER_W-1:0]      per_new;
   logic [PER_W-1:0]      per_target;

   // Result of completing on the current rise.
   always_comb begin
      sample     = {1'b0, cnt_q} + (CNT_W+1)'(1);
      acc_new    = sat_add(acc_q, sample);
      acc_avg    = acc_new >> n_r_q;
      avg_ovf    = |acc_avg[ACC_W-1:PER_W];
      period_new = avg_ovf ? {PER_W{1'b1}} : acc_avg[PER_W-1:0];
      diff       = $signed({1'b0, period_new}) - $signed({1'b0, k_exp});
      // A clamped reading is out of range and never counts as a match,
      // even when k_exp sits at full scale.
      in_tol     = !avg_ovf && (diff >= -9'sd1) && (diff <= 9'sd1);
      per_new    = per_cnt_q + PER_W'(1);
      per_target = PER_W'(1) << n_r_q;
   end

   always_comb begin
      state_d   = state_q;
      n_r_d     = n_r_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      per_cnt_d = per_cnt_q;
      period_d  = period_q;
      done_d    = 1'b0;
      match_d   = match_q;
      timeout_d = timeout_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_ARM;
               n_r_d     = n;
               acc_d     = '0;
               cnt_d     = '0;
               per_cnt_d = '0;
               match_d   = 1'b0;
               timeout_d = 1'b0;
            end
         end

         ST_ARM: begin
            if (rise) begin
               // Arming edge only starts the first period; it is not a sample.
               state_d = ST_MEASURE;
               cnt_d   = '0;
            end else if (cnt_q == TIMEOUT_MAX) begin
               state_d   = ST_DONE;
               done_d    = 1'b1;
               timeout_d = 1'b1;
               period_d  = '0;
               match_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_MEASURE: begin
            if (rise) begin
               acc_d     = acc_new;
               cnt_d     = '0;
               per_cnt_d = per_new;
               if (per_new == per_target) begin
                  state_d  = ST_DONE;
                  done_d   = 1'b1;
                  period_d = period_new;
                  match_d  = in_tol;
               end
            end else if (cnt_q == TIMEOUT_MAX) begin
               state_d   = ST_DONE;
               done_d    = 1'b1;
               timeout_d = 1'b1;
               period_d  = '0;
               match_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         n_r_q     <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         per_cnt_q <= '0;
         period_q  <= '0;
         done_q    <= 1'b0;
         match_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_r_q     <= n_r_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         per_cnt_q <= per_cnt_d;
         period_q  <= period_d;
         done_q    <= done_d;
         match_q   <= match_d;
         timeout_q <= timeout_d;
      end
   end

   assign period   = period_q;
   assign done     = done_q;
   assign match    = match_q;
   assign timeout  = timeout_q;
   assign curState = state_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter
//   Drives sig_in as a square wave built from a list of per-period lengths
//   (changing on the falling clk edge) and compares the meter outputs with a
//   model that averages the period lengths directly.
module tb_freq_meter;

   logic       clk = 1'b0;
   logic       rst;
   logic       sig_in;
   logic       start;
   logic [2:0] n;
   logic [7:0] k_exp;
   logic [7:0] period;
   logic       done;
   logic       match;
   logic       timeout;
   logic [2:0] cur_state;

   int checks = 0;
   int passes = 0;

   int         cyc = 0;
   int         done_cnt = 0;
   int         done_cyc = 0;
   logic       done_match = 1'b0;
   logic [7:0] done_period = 8'd0;

   int wave[$];

   freq_meter dut (
      .clk      (clk),
      .rst      (rst),
      .sig_in   (sig_in),
      .start    (start),
      .n        (n),
      .k_exp    (k_exp),
      .period   (period),
      .done     (done),
      .match    (match),
      .timeout  (timeout),
      .curState (cur_state)
   );

   always #5 clk = ~clk;

   // Counts done-high cycles and snapshots the result seen with each one.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (done === 1'b1) begin
         done_cnt    = done_cnt + 1;
         done_cyc    = cyc;
         done_match  = match;
         done_period = period;
      end
   end

   // Reference: average of the first 2^nn period lengths of the wave.
   function automatic int avg_model(input int nn);
      int sum;
      sum = 0;
      for (int i = 0; i < (1 << nn); i++) sum += wave[i];
      if (sum > 65535) sum = 65535;
      return sum >> nn;
   endfunction

   function automatic bit match_model(input int avg, input int kk);
      return (avg <= 255) && (avg - kk <= 1) && (kk - avg <= 1);
   endfunction

   task automatic start_run(input int nn, input int kk);
      @(negedge clk);
      n     = 3'(nn);
      k_exp = 8'(kk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Each entry is one period: high for the first half, low for the rest.
   task automatic run_wave();
      foreach (wave[i]) begin
         for (int c = 0; c < wave[i]; c++) begin
            @(negedge clk);
            sig_in = (c < wave[i] / 2);
         end
      end
      @(negedge clk);
      sig_in = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget);
      for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (period !== 8'd0) $display("FAIL reset_period got %0d want 0", period); else passes++;
      checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passes++;
      checks++; if (match !== 1'b0) $display("FAIL reset_match got %b want 0", match); else passes++;
      checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", timeout); else passes++;
      checks++; if (cur_state !== 3'd0) $display("FAIL reset_state got %0d want 0", cur_state); else passes++;
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_basic();
      int d0;
      wave = {20, 10};
      d0 = done_cnt;
      start_run(0, 20);
      run_wave();
      wait_done(d0, 20);
      checks++; if (done_cnt - d0 !== 1) $display("FAIL basic_done_count got %0d want 1", done_cnt - d0); else passes++;
      checks++; if (period !== 8'd20) $display("FAIL basic_period got %0d want 20", period); else passes++;
      checks++; if (match !== 1'b1) $display("FAIL basic_match got %b want 1", match); else passes++;
      checks++; if (timeout !== 1'b0) $display("FAIL basic_timeout got %b want 0", timeout); else passes++;
      checks++; if (cur_state !== 3'd3) $display("FAIL basic_state got %0d want 3", cur_state); else passes++;
   endtask

   task automatic test_alternating();
      int d0;
      wave = {18, 22, 18, 22, 18, 22, 18, 22, 10};
      d0 = done_cnt;
      start_run(3, 25);
      run_wave();
      wait_done(d0, 20);
      checks++; if (done_cnt - d0 !== 1) $display("FAIL alt_done_count got %0d want 1", done_cnt - d0); else passes++;
      checks++; if (period !== 8'd20) $display("FAIL alt_period got %0d want 20", period); else passes++;
      checks++; if (match !== 1'b0) $display("FAIL alt_match got %b want 0", match); else passes++;
      checks++; if (timeout !== 1'b0) $display("FAIL alt_timeout got %b want 0", timeout); else passes++;
   endtask

   task automatic test_saturate();
      int d0;
      wave = {300, 10};
      d0 = done_cnt;
      start_run(0, 255);
      run_wave();
      wait_done(d0, 20);
      checks++; if (done_cnt - d0 !== 1) $display("FAIL sat_done_count got %0d want 1", done_cnt - d0); else passes++;
      checks++; if (period !== 8'd255) $display("FAIL sat_period got %0d want 255", period); else passes++;
      checks++; if (match !== 1'b0) $display("FAIL sat_match got %b want 0", match); else passes++;
      checks++; if (timeout !== 1'b0) $display("FAIL sat_timeout got %b want 0", timeout); else passes++;
   endtask

   // Random averaging depth and periods; a start pulse and an n change land
   // mid-run and must be ignored.
   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         int nn, kk, avg, exp_per, d0, pulse_at;
         bit exp_match;
         nn   = int'($urandom_range(3, 0));
         wave = {};
         for (int i = 0; i < (1 << nn); i++) wave.push_back(int'($urandom_range(60, 4)));
         wave.push_back(10);
         avg = avg_model(nn);
         if ($urandom_range(1, 0) == 1) kk = avg + int'($urandom_range(2, 0)) - 1;
         else                           kk = int'($urandom_range(255, 0));
         exp_per   = (avg > 255) ? 255 : avg;
         exp_match = match_model(avg, kk);
         pulse_at  = (nn == 0) ? 2 : wave[0] + 3;
         d0 = done_cnt;
         start_run(nn, kk);
         fork
            run_wave();
            begin
               repeat (pulse_at) @(negedge clk);
               start = 1'b1;
               n     = 3'($urandom_range(7, 0));
               @(negedge clk);
               start = 1'b0;
            end
         join
         wait_done(d0, 20);
         checks++; if (done_cnt - d0 !== 1) $display("FAIL rand%0d_done_count got %0d want 1", r, done_cnt - d0); else passes++;
         checks++; if (period !== 8'(exp_per)) $display("FAIL rand%0d_period n=%0d got %0d want %0d", r, nn, period, exp_per); else passes++;
         checks++; if (match !== exp_match) $display("FAIL rand%0d_match k=%0d got %b want %b", r, kk, match, exp_match); else passes++;
         checks++; if (timeout !== 1'b0) $display("FAIL rand%0d_timeout got %b want 0", r, timeout); else passes++;
      end
   endtask

   task automatic test_reset_mid();
      int d0;
      wave = {20, 20, 20};
      start_run(3, 20);
      run_wave();
      repeat (2) @(negedge clk);
      checks++; if (cur_state !== 3'd2) $display("FAIL rstmid_pre_state got %0d want 2", cur_state); else passes++;
      d0  = done_cnt;
      rst = 1'b1;
      #1;
      checks++; if (period !== 8'd0) $display("FAIL rstmid_period got %0d want 0", period); else passes++;
      checks++; if (done !== 1'b0) $display("FAIL rstmid_done got %b want 0", done); else passes++;
      checks++; if (match !== 1'b0) $display("FAIL rstmid_match got %b want 0", match); else passes++;
      checks++; if (timeout !== 1'b0) $display("FAIL rstmid_timeout got %b want 0", timeout); else passes++;
      checks++; if (cur_state !== 3'd0) $display("FAIL rstmid_state got %0d want 0", cur_state); else passes++;
      @(negedge clk);
      rst = 1'b0;
      wave = {20, 20, 20, 20, 20, 20, 20};
      run_wave();
      repeat (5) @(negedge clk);
      checks++; if (done_cnt - d0 !== 0) $display("FAIL rstmid_no_done got %0d want 0", done_cnt - d0); else passes++;
      wave = {30, 30, 10};
      d0 = done_cnt;
      start_run(1, 30);
      run_wave();
      wait_done(d0, 20);
      checks++; if (done_cnt - d0 !== 1) $display("FAIL remeas_done_count got %0d want 1", done_cnt - d0); else passes++;
      checks++; if (period !== 8'd30) $display("FAIL remeas_period got %0d want 30", period); else passes++;
      checks++; if (match !== 1'b1) $display("FAIL remeas_match got %b want 1", match); else passes++;
   endtask

   task automatic test_timeout();
      int d0, arm_cyc;
      sig_in = 1'b0;
      d0 = done_cnt;
      @(negedge clk);
      n     = 3'd2;
      k_exp = 8'd0;
      start = 1'b1;
      @(posedge clk);
      #2;
      arm_cyc = cyc;
      start   = 1'b0;
      checks++; if (cur_state !== 3'd1) $display("FAIL tmo_arm_state got %0d want 1", cur_state); else passes++;
      wait_done(d0, 70000);
      checks++; if (done_cnt - d0 !== 1) $display("FAIL tmo_done_count got %0d want 1", done_cnt - d0); else passes++;
      checks++; if (done_cyc - arm_cyc !== 65536) $display("FAIL tmo_latency got %0d want 65536", done_cyc - arm_cyc); else passes++;
      checks++; if (timeout !== 1'b1) $display("FAIL tmo_flag got %b want 1", timeout); else passes++;
      checks++; if (period !== 8'd0) $display("FAIL tmo_period got %0d want 0", period); else passes++;
      checks++; if (match !== 1'b0) $display("FAIL tmo_match got %b want 0", match); else passes++;
   endtask

   // start stays high: every run consumes one arming rise plus 2^n sample
   // rises, then re-arms straight from DONE.
   task automatic test_back_to_back();
      int d0, exp_runs;
      wave = {};
      for (int i = 0; i < 8; i++) wave.push_back(16);
      wave.push_back(10);
      exp_runs = wave.size() / 2;
      d0 = done_cnt;
      @(negedge clk);
      n     = 3'd0;
      k_exp = 8'd16;
      start = 1'b1;
      run_wave();
      start = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if (done_cnt - d0 !== exp_runs) $display("FAIL b2b_done_count got %0d want %0d", done_cnt - d0, exp_runs); else passes++;
      checks++; if (done_period !== 8'd16) $display("FAIL b2b_period got %0d want 16", done_period); else passes++;
      checks++; if (done_match !== 1'b1) $display("FAIL b2b_match got %b want 1", done_match); else passes++;
   endtask

   initial begin
      rst    = 1'b1;
      sig_in = 1'b0;
      start  = 1'b0;
      n      = 3'd0;
      k_exp  = 8'd0;
      test_reset();
      test_basic();
      test_alternating();
      test_saturate();
      test_random();
      test_reset_mid();
      test_timeout();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
